mem_cfg_regfile: RTL

Parametrised memory-mapped configuration register file for the switch: the slave side of the memory interface that the testbench drives. It holds one destination-address register per switch port and serves write/read requests through a three-state handshake. It returns a one-hot per-port acknowledge on writes, registered read data with a valid strobe, and an error strobe for illegal accesses. The per-port registers are exported as a flat bus to the switch datapath.

---
 rtl/mem_cfg_regfile.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/mem_cfg_regfile.sv
// mem_cfg_regfile: memory-mapped per-port destination-address register file.
// Accesses run through a three-state handshake (IDLE -> ACCESS -> RESP). The request
// is captured in IDLE and performed at the ACCESS edge. The response strobes are
// registered out of RESP.
//
// Ports:
//   clk, rst_n     clock, asynchronous active-low reset
//   mem_sel_en     request strobe (sampled in IDLE only)
//   mem_addr       register address
//   mem_wr_data    write data
//   mem_wr_rd_s    1 = write, 0 = read
//   mem_rd_data    read data, held until the next successful read
//   mem_rd_valid   one-cycle read-complete pulse
//   mem_ack        one-hot one-cycle write-complete pulse per port
//   mem_err        one-cycle access-rejected pulse
//   mem_busy       transaction in flight
//   port_cfg_o     flat bus of all port registers, port i at [i*DATA_W +: DATA_W]
//
// Optional feature: define MEM_CFG_LOCK_EN to add a sticky write-lock register
// at BASE_ADDR+NUM_PORTS.

module mem_cfg_regfile #(
    parameter int unsigned           NUM_PORTS = 4,
    parameter int unsigned           ADDR_W    = 8,
    parameter int unsigned           DATA_W    = 8,
    parameter logic [ADDR_W-1:0]     BASE_ADDR = ADDR_W'(0)
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        mem_sel_en,
    input  logic [ADDR_W-1:0]           mem_addr,
    input  logic [DATA_W-1:0]           mem_wr_data,
    input  logic                        mem_wr_rd_s,
    output logic [DATA_W-1:0]           mem_rd_data,
    output logic                        mem_rd_valid,
    output logic [NUM_PORTS-1:0]        mem_ack,
    output logic                        mem_err,
    output logic                        mem_busy,
    output logic [NUM_PORTS*DATA_W-1:0] port_cfg_o
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    state_t state, state_n;

    logic [ADDR_W-1:0]           addr_q;
    logic [DATA_W-1:0]           data_q;
    logic                        wr_q;
    logic [NUM_PORTS*DATA_W-1:0] cfg_q;

    // Response latched at the ACCESS edge, presented out of RESP.
    logic [NUM_PORTS-1:0]        ack_pend;
    logic                        valid_pend;
    logic                        err_pend;

    // Decode of the captured request.
    logic [ADDR_W-1:0]           idx_c;
    logic                        hit_port_c;
    logic                        hit_lock_c;
    logic                        locked_c;
    logic [NUM_PORTS-1:0]        port_sel_c;
    logic [DATA_W-1:0]           rd_val_c;
    logic                        do_wr_c;
    logic                        do_rd_c;
    logic                        set_lock_c;
    logic                        err_c;

`ifdef MEM_CFG_LOCK_EN
    logic lock_q;
`endif

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_n;
    end

    // Next-state logic.
    always_comb begin
        state_n = state;
        case (state)
            IDLE:    if (mem_sel_en) state_n = ACCESS;
            ACCESS:  state_n = RESP;
            RESP:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // Address decode and access outcome for the held request.
    always_comb begin
        idx_c      = addr_q - BASE_ADDR;
        hit_port_c = (addr_q >= BASE_ADDR) && (idx_c < ADDR_W'(NUM_PORTS));
        port_sel_c = '0;
        rd_val_c   = '0;
        for (int unsigned i = 0; i < NUM_PORTS; i++) begin
            if (hit_port_c && idx_c == ADDR_W'(i)) begin
                port_sel_c[i] = 1'b1;
                rd_val_c      = cfg_q[i*DATA_W +: DATA_W];
            end
        end
`ifdef MEM_CFG_LOCK_EN
        hit_lock_c = (addr_q >= BASE_ADDR) && (idx_c == ADDR_W'(NUM_PORTS));
        locked_c   = lock_q;
        if (hit_lock_c) rd_val_c = DATA_W'(lock_q);
`else
        hit_lock_c = 1'b0;
        locked_c   = 1'b0;
`endif
        do_wr_c    = wr_q && hit_port_c && !locked_c;
        do_rd_c    = !wr_q && (hit_port_c || hit_lock_c);
        set_lock_c = wr_q && hit_lock_c && data_q[0];
        // Lock writes (0 or 1) complete silently: no ack, no error.
        err_c      = !(hit_port_c || hit_lock_c) || (wr_q && hit_port_c && locked_c);
    end

    // Request capture, register update and response strobes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q       <= '0;
            data_q       <= '0;
            wr_q         <= 1'b0;
            cfg_q        <= '0;
            ack_pend     <= '0;
            valid_pend   <= 1'b0;
            err_pend     <= 1'b0;
            mem_rd_data  <= '0;
            mem_rd_valid <= 1'b0;
            mem_ack      <= '0;
            mem_err      <= 1'b0;
            mem_busy     <= 1'b0;
        end else begin
            if (state == IDLE && mem_sel_en) begin
                addr_q <= mem_addr;
                data_q <= mem_wr_data;
                wr_q   <= mem_wr_rd_s;
            end
            if (state == ACCESS) begin
                for (int unsigned i = 0; i < NUM_PORTS; i++) begin
                    if (do_wr_c && port_sel_c[i]) cfg_q[i*DATA_W +: DATA_W] <= data_q;
                end
                if (do_rd_c) mem_rd_data <= rd_val_c;
                ack_pend   <= do_wr_c ? port_sel_c : '0;
                valid_pend <= do_rd_c;
                err_pend   <= err_c;
            end
            mem_ack      <= (state == RESP) ? ack_pend : '0;
            mem_rd_valid <= (state == RESP) && valid_pend;
            mem_err      <= (state == RESP) && err_pend;
            // Covers the capture edge through the edge leaving RESP.
            mem_busy     <= (state_n != IDLE) || (state != IDLE);
        end
    end

`ifdef MEM_CFG_LOCK_EN
    // Sticky lock, cleared only by reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                           lock_q <= 1'b0;
        else if (state == ACCESS && set_lock_c) lock_q <= 1'b1;
    end
`endif

    assign port_cfg_o = cfg_q;

endmodule
